// File: rtl/fib_sched_if.sv
// fib_sched_if: requester-side and core-side signals of the Fibonacci job scheduler.
// Latency: none, this is a plain signal bundle.
// Backpressure: requesters hold req until ack; the core holds done until it accepts go.
interface fib_sched_if #(
  parameter int NUM_REQ      = 4,
  parameter int INPUT_WIDTH  = 6,
  parameter int OUTPUT_WIDTH = 32
);
  // Requester side
  logic [NUM_REQ-1:0]             req;
  logic [NUM_REQ*INPUT_WIDTH-1:0] req_n;
  logic [NUM_REQ-1:0]             ack;
  logic [NUM_REQ-1:0]             resp_valid;
  logic [OUTPUT_WIDTH-1:0]        resp_result;
  logic                           resp_overflow;
  logic                           resp_error;
  logic                           busy;

  // Shared Fibonacci core side
  logic                           core_go;
  logic [INPUT_WIDTH-1:0]         core_n;
  logic [OUTPUT_WIDTH-1:0]        core_result;
  logic                           core_overflow;
  logic                           core_done;

  // Scheduler view
  modport slave (
    input  req, req_n, core_result, core_overflow, core_done,
    output ack, resp_valid, resp_result, resp_overflow, resp_error, busy,
           core_go, core_n
  );

  // Requesters plus core view
  modport master (
    output req, req_n, core_result, core_overflow, core_done,
    input  ack, resp_valid, resp_result, resp_overflow, resp_error, busy,
           core_go, core_n
  );
endinterface

// File: rtl/fib_sched.sv
// fib_sched: round-robin scheduler sharing one Fibonacci core among NUM_REQ requesters.
// Latency: ack 1 cycle after req is seen in IDLE; resp_valid 1 cycle after core_done is seen.
// Backpressure: one job outstanding; other requests stay pending (req held) until next IDLE.
// Optional watchdog: define FIB_SCHED_TIMEOUT_EN to bound the wait for core_done.
module fib_sched #(
  parameter int NUM_REQ        = 4,
  parameter int INPUT_WIDTH    = 6,
  parameter int OUTPUT_WIDTH   = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst,
  fib_sched_if.slave bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  typedef logic [IDX_W-1:0] idx_t;
  localparam idx_t LAST_IDX = idx_t'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_CLEAR,
    WAIT_DONE,
    RESPOND,
    RECOVER
  } state_e;

  state_e                  state_q;
  idx_t                    last_grant_q;
  idx_t                    winner_q;
  logic [INPUT_WIDTH-1:0]  n_q;
  logic [NUM_REQ-1:0]      ack_q;
  logic [NUM_REQ-1:0]      resp_valid_q;
  logic [OUTPUT_WIDTH-1:0] result_q;
  logic                    overflow_q;
  logic                    go_q;

  // Arbitration results for the current cycle
  logic                    grant_vld;
  idx_t                    winner_d;
  logic [INPUT_WIDTH-1:0]  n_d;
  int                      cand;
  idx_t                    cand_idx;

`ifdef FIB_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] to_cnt_q;
  logic             error_q;
  logic             to_hit;

  // The current wait cycle is the last one the watchdog allows.
  assign to_hit = (to_cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1));
`else
  // The watchdog limit is only meaningful with the watchdog compiled in.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

  function automatic logic [NUM_REQ-1:0] onehot(input idx_t i);
    logic [NUM_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Round-robin search starting just after the last requester served.
  always_comb begin
    grant_vld = 1'b0;
    winner_d  = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand     = (int'(last_grant_q) + 1 + k) % NUM_REQ;
      cand_idx = idx_t'(cand);
      if (!grant_vld && bus.req[cand_idx]) begin
        grant_vld = 1'b1;
        winner_d  = cand_idx;
      end
    end
  end

  // Select the winner's n from the packed request bus.
  always_comb begin
    n_d = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (idx_t'(k) == winner_d) begin
        n_d = bus.req_n[k*INPUT_WIDTH +: INPUT_WIDTH];
      end
    end
  end

  // Job sequencing FSM; all outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= LAST_IDX;
      winner_q     <= '0;
      n_q          <= '0;
      ack_q        <= '0;
      resp_valid_q <= '0;
      result_q     <= '0;
      overflow_q   <= 1'b0;
      go_q         <= 1'b0;
`ifdef FIB_SCHED_TIMEOUT_EN
      to_cnt_q     <= '0;
      error_q      <= 1'b0;
`endif
    end else begin
      // ack, go and resp_valid are single-cycle pulses.
      ack_q        <= '0;
      resp_valid_q <= '0;
      go_q         <= 1'b0;

      case (state_q)
        IDLE: begin
          if (grant_vld) begin
            winner_q <= winner_d;
            n_q      <= n_d;
            ack_q    <= onehot(winner_d);
            go_q     <= 1'b1;
            state_q  <= ISSUE;
          end
        end

        ISSUE: begin
`ifdef FIB_SCHED_TIMEOUT_EN
          to_cnt_q <= '0;
`endif
          state_q <= WAIT_CLEAR;
        end

        // core_done may still be high from the previous job; wait for it to drop.
        WAIT_CLEAR: begin
`ifdef FIB_SCHED_TIMEOUT_EN
          if (to_hit) begin
            resp_valid_q <= onehot(winner_q);
            result_q     <= '0;
            overflow_q   <= 1'b0;
            error_q      <= 1'b1;
            state_q      <= RESPOND;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
            if (!bus.core_done) state_q <= WAIT_DONE;
          end
`else
          if (!bus.core_done) state_q <= WAIT_DONE;
`endif
        end

        // A real result wins over a watchdog expiry in the same cycle.
        WAIT_DONE: begin
          if (bus.core_done) begin
            result_q     <= bus.core_result;
            overflow_q   <= bus.core_overflow;
            resp_valid_q <= onehot(winner_q);
            state_q      <= RESPOND;
`ifdef FIB_SCHED_TIMEOUT_EN
          end else if (to_hit) begin
            resp_valid_q <= onehot(winner_q);
            result_q     <= '0;
            overflow_q   <= 1'b0;
            error_q      <= 1'b1;
            state_q      <= RESPOND;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
`endif
          end
        end

        // Response is on the bus this cycle; clear it afterwards.
        RESPOND: begin
          last_grant_q <= winner_q;
          result_q     <= '0;
          overflow_q   <= 1'b0;
`ifdef FIB_SCHED_TIMEOUT_EN
          error_q      <= 1'b0;
          state_q      <= error_q ? RECOVER : IDLE;
`else
          state_q      <= IDLE;
`endif
        end

        // The abandoned job must finish before the core can take another one.
        RECOVER: begin
          if (bus.core_done) state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ack           = ack_q;
  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_result   = result_q;
  assign bus.resp_overflow = overflow_q;
  assign bus.busy          = (state_q != IDLE);
  assign bus.core_go       = go_q;
  assign bus.core_n        = n_q;
`ifdef FIB_SCHED_TIMEOUT_EN
  assign bus.resp_error    = error_q;
`else
  assign bus.resp_error    = 1'b0;
`endif

endmodule

// File: tb/tb_fib_sched.sv
// tb_fib_sched: directed bench for fib_sched with a behavioural Fibonacci core.
// Latency: core answers core_lat cycles after the done-clear cycle (stallable).
// Backpressure: requesters hold req until ack, as the scheduler expects.
`timescale 1ns/1ps
module tb_fib_sched;
  localparam int NUM_REQ = 4;
  localparam int IW      = 6;
  localparam int OW      = 32;
  localparam int TO      = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fib_sched_if #(.NUM_REQ(NUM_REQ), .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW)) bus ();

  fib_sched #(
    .NUM_REQ(NUM_REQ), .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  // ---------------- behavioural core ----------------
  logic [63:0] fib_tab [64];
  logic        stall    = 1'b0;
  int          core_lat = 3;
  logic        clr_pend;
  logic        run;
  int          cnt;
  logic [IW-1:0] job_n;

  initial begin
    fib_tab[0] = 64'd0;
    fib_tab[1] = 64'd1;
    for (int i = 2; i < 64; i++) fib_tab[i] = fib_tab[i-1] + fib_tab[i-2];
  end

  // done stays high until go is accepted, then clears the cycle after.
  always @(posedge clk) begin
    if (rst) begin
      bus.core_done     <= 1'b0;
      bus.core_result   <= '0;
      bus.core_overflow <= 1'b0;
      clr_pend <= 1'b0;
      run      <= 1'b0;
      cnt      <= 0;
      job_n    <= '0;
    end else if (bus.core_go) begin
      clr_pend <= 1'b1;
      run      <= 1'b1;
      cnt      <= core_lat;
      job_n    <= bus.core_n;
    end else if (clr_pend) begin
      clr_pend      <= 1'b0;
      bus.core_done <= 1'b0;
    end else if (run && !stall) begin
      if (cnt == 0) begin
        run               <= 1'b0;
        bus.core_done     <= 1'b1;
        bus.core_result   <= fib_tab[job_n][31:0];
        bus.core_overflow <= |fib_tab[job_n][63:32];
      end else begin
        cnt <= cnt - 1;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NUM_REQ-1:0] oh(input int i);
    logic [NUM_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic set_n(input int i, input int n);
    bus.req_n[i*IW +: IW] = IW'(n);
  endtask

  task automatic wait_idle(input int budget);
    int c;
    c = 0;
    while (bus.busy && c < budget) begin
      step();
      c++;
    end
    if (bus.busy) check("wait_idle_budget", 64'd1, 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  int                 ack_q[$];
  logic [NUM_REQ-1:0] rsp_vec_q[$];
  logic [31:0]        rsp_res_q[$];
  logic               rsp_ovf_q[$];
  logic               rsp_err_q[$];
  int                 go_cnt;

  // Watches acks, core_go and responses until want responses arrive or budget runs out.
  task automatic run_mon(input int want, input int budget, input bit drop_on_ack);
    logic prev_done;
    ack_q.delete(); rsp_vec_q.delete(); rsp_res_q.delete();
    rsp_ovf_q.delete(); rsp_err_q.delete();
    go_cnt    = 0;
    prev_done = bus.core_done;
    for (int c = 0; c < budget && rsp_vec_q.size() < want; c++) begin
      step();
      if (bus.core_go) go_cnt++;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.ack[i]) begin
          ack_q.push_back(i);
          if (drop_on_ack) bus.req[i] = 1'b0;
        end
      end
      if (bus.resp_valid != '0) begin
        rsp_vec_q.push_back(bus.resp_valid);
        rsp_res_q.push_back(bus.resp_result);
        rsp_ovf_q.push_back(bus.resp_overflow);
        rsp_err_q.push_back(bus.resp_error);
        if (!bus.resp_error) check("resp_one_after_done", 64'(prev_done), 64'd1);
      end
      prev_done = bus.core_done;
    end
    if (rsp_vec_q.size() < want) check("resp_count_budget", 64'(rsp_vec_q.size()), 64'(want));
  endtask

  typedef struct {
    int          idx;
    int          n;
    logic [31:0] exp_res;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int seen;
    int exp_ack[6];
    int exp_res4[6];

    vecs[0] = '{idx: 1, n: 10, exp_res: 32'd55,         exp_ovf: 1'b0};
    vecs[1] = '{idx: 0, n: 0,  exp_res: 32'd0,          exp_ovf: 1'b0};
    vecs[2] = '{idx: 2, n: 1,  exp_res: 32'd1,          exp_ovf: 1'b0};
    vecs[3] = '{idx: 3, n: 47, exp_res: 32'd2971215073, exp_ovf: 1'b0};
    vecs[4] = '{idx: 0, n: 48, exp_res: 32'd512559680,  exp_ovf: 1'b1};
    vecs[5] = '{idx: 1, n: 3,  exp_res: 32'd2,          exp_ovf: 1'b0};

    bus.req   = '0;
    bus.req_n = '0;

    // ---- reset state ----
    rst = 1'b1;
    repeat (3) step();
    check("rst_ack",        bus.ack,           0);
    check("rst_resp_valid", bus.resp_valid,    0);
    check("rst_result",     bus.resp_result,   0);
    check("rst_overflow",   bus.resp_overflow, 0);
    check("rst_error",      bus.resp_error,    0);
    check("rst_busy",       bus.busy,          0);
    check("rst_core_go",    bus.core_go,       0);
    check("rst_core_n",     bus.core_n,        0);
    rst = 1'b0;
    step();

    // ---- single-request table ----
    foreach (vecs[v]) begin
      wait_idle(50);
      set_n(vecs[v].idx, vecs[v].n);
      bus.req[vecs[v].idx] = 1'b1;
      step();
      check("ack_next_cycle", bus.ack, oh(vecs[v].idx));
      check("go_with_ack",    bus.core_go, 1);
      check("core_n_issue",   bus.core_n, vecs[v].n);
      bus.req[vecs[v].idx] = 1'b0;
      run_mon(1, 100, 1'b0);
      if (rsp_vec_q.size() == 1) begin
        check("tbl_resp_vec", rsp_vec_q[0], oh(vecs[v].idx));
        check("tbl_result",   rsp_res_q[0], vecs[v].exp_res);
        check("tbl_overflow", rsp_ovf_q[0], vecs[v].exp_ovf);
        check("tbl_error",    rsp_err_q[0], 0);
      end
      step();
      check("tbl_result_cleared", bus.resp_valid, 0);
    end

    // ---- two simultaneous requests: 0 then 2 ----
    do_reset();
    set_n(0, 5);
    set_n(2, 7);
    bus.req = 4'b0101;
    run_mon(2, 200, 1'b1);
    if (rsp_vec_q.size() == 2) begin
      check("dual_first_vec",  rsp_vec_q[0], oh(0));
      check("dual_first_res",  rsp_res_q[0], 5);
      check("dual_second_vec", rsp_vec_q[1], oh(2));
      check("dual_second_res", rsp_res_q[1], 13);
    end
    bus.req = '0;
    wait_idle(50);

    // ---- all four held: 0,1,2,3,0,1 ----
    do_reset();
    set_n(0, 2); set_n(1, 4); set_n(2, 6); set_n(3, 8);
    exp_ack  = '{0, 1, 2, 3, 0, 1};
    exp_res4 = '{1, 3, 8, 21, 1, 3};
    bus.req = 4'b1111;
    run_mon(6, 400, 1'b0);
    bus.req = '0;
    check("rr_ack_count", ack_q.size(), 6);
    check("rr_go_count",  go_cnt, 6);
    for (int k = 0; k < 6; k++) begin
      if (k < ack_q.size()) check("rr_grant_order", ack_q[k], exp_ack[k]);
      if (k < rsp_vec_q.size()) begin
        check("rr_resp_vec", rsp_vec_q[k], oh(exp_ack[k]));
        check("rr_resp_res", rsp_res_q[k], exp_res4[k]);
      end
    end
    wait_idle(50);

    // ---- reset in WAIT_DONE ----
    do_reset();
    core_lat = 10;
    set_n(1, 20);
    bus.req[1] = 1'b1;
    step();
    check("mid_ack", bus.ack, oh(1));
    bus.req[1] = 1'b0;
    repeat (4) step();
    check("mid_busy",      bus.busy, 1);
    check("mid_no_resp",   bus.resp_valid, 0);
    rst = 1'b1;
    step();
    check("mid_rst_ack",   bus.ack, 0);
    check("mid_rst_rv",    bus.resp_valid, 0);
    check("mid_rst_res",   bus.resp_result, 0);
    check("mid_rst_ovf",   bus.resp_overflow, 0);
    check("mid_rst_err",   bus.resp_error, 0);
    check("mid_rst_busy",  bus.busy, 0);
    check("mid_rst_go",    bus.core_go, 0);
    check("mid_rst_n",     bus.core_n, 0);
    rst = 1'b0;
    seen = 0;
    repeat (20) begin
      step();
      if (bus.resp_valid != '0) seen++;
    end
    check("mid_no_late_resp", seen, 0);
    core_lat = 3;
    set_n(2, 3);
    bus.req[2] = 1'b1;
    run_mon(1, 100, 1'b1);
    if (rsp_vec_q.size() == 1) begin
      check("post_rst_vec", rsp_vec_q[0], oh(2));
      check("post_rst_res", rsp_res_q[0], 2);
    end
    wait_idle(50);

`ifdef FIB_SCHED_TIMEOUT_EN
    // ---- watchdog with a stalled core ----
    do_reset();
    stall = 1'b1;
    set_n(0, 4);
    bus.req[0] = 1'b1;
    step();
    check("to_ack", bus.ack, oh(0));
    bus.req[0] = 1'b0;
    // 16 wait cycles follow ISSUE; the error response lands on the next one.
    lat = 0;
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      step();
      if (bus.resp_valid != '0) lat = c;
    end
    check("to_latency",  lat, 17);
    check("to_resp_vec", bus.resp_valid, oh(0));
    check("to_error",    bus.resp_error, 1);
    check("to_result",   bus.resp_result, 0);
    check("to_overflow", bus.resp_overflow, 0);
    set_n(1, 6);
    bus.req[1] = 1'b1;
    seen = 0;
    repeat (12) begin
      step();
      if (bus.ack != '0) seen++;
    end
    check("to_no_ack_recover", seen, 0);
    check("to_busy_recover",   bus.busy, 1);
    stall = 1'b0;
    run_mon(1, 100, 1'b1);
    if (ack_q.size() > 0) check("to_next_ack", ack_q[0], 1);
    if (rsp_vec_q.size() == 1) begin
      check("to_next_res", rsp_res_q[0], 8);
      check("to_next_err", rsp_err_q[0], 0);
    end
    wait_idle(50);
`else
    lat = 0;
    check("no_wd_error", bus.resp_error, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
